// File: rtl/edge_frame_packer_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the edge-frame packer:
//   - packer_state_t : top-level FSM encoding
//   - BYTE_W         : width of a packed bitmap byte
//   - calc_nbytes()  : bytes needed for an H_RES x V_RES 1-bpp bitmap
//   - calc_addr_w()  : RAM address width for a given byte count
// -----------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} packer_state_t;

  localparam int BYTE_W = 8;

  function automatic int calc_nbytes(input int h_res, input int v_res);
    return (h_res * v_res) / BYTE_W;
  endfunction

  // A single-entry RAM still needs a 1-bit address port.
  function automatic int calc_addr_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/edge_frame_packer_if.sv
// -----------------------------------------------------------------------------
// edge_frame_packer_if
// Byte stream carrying the packed bitmap out of the packer.
//   o_tdata  : packed bitmap byte (MSB = earliest pixel)
//   o_tvalid : byte valid
//   i_tready : downstream accept
//   o_tlast  : final byte of the frame
// Signal names are seen from the packer (master) side.
// -----------------------------------------------------------------------------
interface edge_frame_packer_if;
  import edge_pkg::*;

  logic [BYTE_W-1:0] o_tdata;
  logic              o_tvalid;
  logic              i_tready;
  logic              o_tlast;

  modport master (output o_tdata, output o_tvalid, output o_tlast, input i_tready);
  modport slave  (input o_tdata, input o_tvalid, input o_tlast, output i_tready);

endinterface

// File: rtl/edge_frame_packer_bitmap_ram.sv
// -----------------------------------------------------------------------------
// edge_bitmap_ram
// Simple dual-port byte RAM holding the packed frame bitmap.
//   clk     : clock for both ports
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write byte
//   i_re    : read enable; o_rdata holds its value while low
//   i_raddr : read address
//   o_rdata : registered read data, valid one cycle after i_re
// -----------------------------------------------------------------------------
module edge_bitmap_ram
  import edge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [BYTE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // No reset on the read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/edge_frame_packer.sv
// -----------------------------------------------------------------------------
// edge_frame_packer
// Captures one frame of the binary edge stream into a 1-bit-per-pixel bitmap
// (packed MSB-first into bytes) and then streams the bitmap out as bytes.
//   clk, rst            : clock, asynchronous active-high reset
//   i_start             : capture request (honoured in IDLE only)
//   i_abort             : return to IDLE from any state, no done/err pulse
//   i_vsync/i_hsync     : syncs from the edge stage (rising vsync = frame start)
//   i_de, i_data        : pixel valid and pixel (nonzero = edge)
//   m_axis              : packed byte stream (o_tdata/o_tvalid/i_tready/o_tlast)
//   o_busy              : high in any state except IDLE
//   o_done              : pulse one cycle after the last byte is accepted
//   o_err               : pulse when a frame restarts before it was complete
// -----------------------------------------------------------------------------
module edge_frame_packer
  import edge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int H_RES = 80,
  parameter int V_RES = 120
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [WIDTH-1:0] i_data,
  edge_frame_packer_if.master m_axis,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int NPIX   = H_RES * V_RES;
  localparam int NBYTES = calc_nbytes(H_RES, V_RES);
  localparam int AW     = calc_addr_w(NBYTES);
  localparam int PCW    = $clog2(NPIX + 1);
  localparam int RCW    = $clog2(NBYTES + 1);

  generate
    if ((H_RES * V_RES) % 8 != 0) begin : g_bad_geometry
      $error("edge_frame_packer: H_RES*V_RES must be a multiple of 8");
    end
  endgenerate

  packer_state_t     r_state, w_state_next;
  logic              r_vsync_q;
  logic              w_vs_rise;
  logic              w_pix_bit;
  logic              w_busy, w_cap_pix, w_in_readout;

  logic [PCW-1:0]    r_pix_cnt;
  logic [AW-1:0]     r_waddr;
  logic [6:0]        r_shift;          // bits 7..1 of the byte being built
  logic              w_we;
  logic [BYTE_W-1:0] w_wdata;

  logic [RCW-1:0]    r_rd_cnt;         // bytes requested from the RAM so far
  logic              r_s1_valid;       // RAM read register holds an unsent byte
  logic              r_s1_last;
  logic [BYTE_W-1:0] r_tdata;
  logic              r_tvalid, r_tlast;
  logic              r_done, r_err;
  logic [BYTE_W-1:0] w_ram_rdata;
  logic              w_xfer, w_s2_free, w_s1_move, w_re;
  logic              w_unused_hsync;

  assign w_unused_hsync = i_hsync;
  assign w_vs_rise      = i_vsync & ~r_vsync_q;
  assign w_pix_bit      = |i_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = ARMED;
      ARMED:   if (w_vs_rise) w_state_next = CAPTURE;
      CAPTURE: if (w_cap_pix && (r_pix_cnt == PCW'(NPIX - 1))) w_state_next = READOUT;
      READOUT: if (w_xfer && r_tlast) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_abort) w_state_next = IDLE;
  end

  // ---------------- FSM: outputs / qualifiers ----------------
  always_comb begin
    w_busy       = (r_state != IDLE);
    // A pixel coinciding with a restarting vsync edge belongs to no frame.
    w_cap_pix    = (r_state == CAPTURE) && i_de && !w_vs_rise && !i_abort;
    w_in_readout = (r_state == READOUT) && !i_abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vsync_q <= 1'b0;
    else     r_vsync_q <= i_vsync;
  end

  // ---------------- capture datapath ----------------
  assign w_we    = w_cap_pix && (r_pix_cnt[2:0] == 3'd7);
  assign w_wdata = {r_shift, w_pix_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= '0;
      r_waddr   <= '0;
      r_shift   <= '0;
    end else if ((r_state == ARMED) || ((r_state == CAPTURE) && w_vs_rise)) begin
      r_pix_cnt <= '0;
      r_waddr   <= '0;
      r_shift   <= '0;
    end else if (w_cap_pix) begin
      r_pix_cnt <= r_pix_cnt + PCW'(1);
      // Stale bits from the previous byte are fully shifted out after 7 pixels.
      r_shift   <= {r_shift[5:0], w_pix_bit};
      if (w_we) r_waddr <= r_waddr + AW'(1);
    end
  end

  edge_bitmap_ram #(
    .DEPTH (NBYTES),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_cnt[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // ---------------- readout datapath ----------------
  // Two-stage pipe: the RAM read register is stage 1 (it holds while i_re is
  // low), the output register is stage 2. A read is issued only when stage 1
  // will have room, so no byte is ever dropped under backpressure.
  assign w_xfer    = r_tvalid && m_axis.i_tready;
  assign w_s2_free = !r_tvalid || m_axis.i_tready;
  assign w_s1_move = r_s1_valid && w_s2_free;
  assign w_re      = w_in_readout && (r_rd_cnt != RCW'(NBYTES)) && (!r_s1_valid || w_s1_move);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else if (!w_in_readout) begin
      r_rd_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      if (w_re) begin
        r_rd_cnt   <= r_rd_cnt + RCW'(1);
        r_s1_last  <= (r_rd_cnt == RCW'(NBYTES - 1));
        r_s1_valid <= 1'b1;
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_move) begin
        r_tdata  <= w_ram_rdata;
        r_tvalid <= 1'b1;
        r_tlast  <= r_s1_last;
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= !i_abort && (r_state == READOUT) && w_xfer && r_tlast;
      r_err  <= !i_abort && (r_state == CAPTURE) && w_vs_rise;
    end
  end

  assign m_axis.o_tdata  = r_tdata;
  assign m_axis.o_tvalid = r_tvalid;
  assign m_axis.o_tlast  = r_tlast;
  assign o_busy          = w_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule

// File: tb/tb_edge_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_edge_frame_packer
// Directed bench: a 16x4 instance (8-byte bitmap) for the functional cases and
// a default 80x120 instance for the full-size all-zero frame.
// -----------------------------------------------------------------------------
module tb_edge_frame_packer;
  import edge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- small instance (16x4) ----------------
  logic       s_start = 1'b0, s_abort = 1'b0, s_vsync = 1'b0, s_hsync = 1'b0, s_de = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_busy, s_done, s_err;
  edge_frame_packer_if s_axis ();

  edge_frame_packer #(.WIDTH(8), .H_RES(16), .V_RES(4)) dut_s (
    .clk     (clk),
    .rst     (rst),
    .i_start (s_start),
    .i_abort (s_abort),
    .i_vsync (s_vsync),
    .i_hsync (s_hsync),
    .i_de    (s_de),
    .i_data  (s_data),
    .m_axis  (s_axis),
    .o_busy  (s_busy),
    .o_done  (s_done),
    .o_err   (s_err)
  );

  // ---------------- default instance (80x120) ----------------
  logic       d_start = 1'b0, d_abort = 1'b0, d_vsync = 1'b0, d_hsync = 1'b0, d_de = 1'b0;
  logic [7:0] d_data = 8'h00;
  logic       d_busy, d_done, d_err;
  edge_frame_packer_if d_axis ();

  edge_frame_packer dut_d (
    .clk     (clk),
    .rst     (rst),
    .i_start (d_start),
    .i_abort (d_abort),
    .i_vsync (d_vsync),
    .i_hsync (d_hsync),
    .i_de    (d_de),
    .i_data  (d_data),
    .m_axis  (d_axis),
    .o_busy  (d_busy),
    .o_done  (d_done),
    .o_err   (d_err)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Small-instance monitor, sampled on the falling edge.
  logic [7:0] q_data[$];
  bit         q_last[$];
  int         s_done_cnt = 0, s_err_cnt = 0, stall_bad = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!s_axis.o_tvalid || s_axis.o_tdata != prev_data || s_axis.o_tlast != prev_last))
        stall_bad <= stall_bad + 1;
      prev_stall <= s_axis.o_tvalid && !s_axis.i_tready && !s_abort;
      prev_data  <= s_axis.o_tdata;
      prev_last  <= s_axis.o_tlast;
      if (s_axis.o_tvalid && s_axis.i_tready) begin
        q_data.push_back(s_axis.o_tdata);
        q_last.push_back(s_axis.o_tlast);
        $display("XFER idx=%0d data=0x%02h last=%0b", q_data.size() - 1, s_axis.o_tdata, s_axis.o_tlast);
      end
      if (s_done) s_done_cnt <= s_done_cnt + 1;
      if (s_err)  s_err_cnt  <= s_err_cnt + 1;
    end
  end

  // Default-instance monitor (counts only; 1200 bytes).
  int d_cnt = 0, d_bad = 0, d_last_cnt = 0, d_last_pos = 0, d_done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (d_axis.o_tvalid && d_axis.i_tready) begin
        d_cnt <= d_cnt + 1;
        if (d_axis.o_tdata != 8'h00) d_bad <= d_bad + 1;
        if (d_axis.o_tlast) begin
          d_last_cnt <= d_last_cnt + 1;
          d_last_pos <= d_cnt + 1;
        end
      end
      if (d_done) d_done_cnt <= d_done_cnt + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int i);
    case (mode)
      0:       return (i % 2 == 0) ? 8'hFF : 8'h00;  // checkerboard
      1:       return (i == 9) ? 8'hFF : 8'h00;      // single edge
      2:       return 8'hFF;                         // all edges
      3:       return (i % 8 == 0) ? 8'h01 : 8'h00;  // small nonzero value, first of byte
      4:       return (i >= 32) ? 8'h5A : 8'h00;     // second half
      default: return 8'h00;
    endcase
  endfunction

  task automatic s_vs_pulse();
    s_vsync = 1'b1; s_de = 1'b0; step();
    s_vsync = 1'b0; step();
  endtask

  // Pixels with a short hsync blanking gap after every 16-pixel line.
  task automatic s_pixels(input int mode, input int n);
    for (int i = 0; i < n; i++) begin
      s_de = 1'b1; s_data = pix_val(mode, i); step();
      if (i % 16 == 15) begin
        s_de = 1'b0; s_data = 8'h00; s_hsync = 1'b1; step();
        s_hsync = 1'b0; step();
      end
    end
    s_de = 1'b0; s_data = 8'h00;
  endtask

  task automatic s_start_pulse();
    s_start = 1'b1; step();
    s_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input bit rand_ready);
    int n = 0;
    while (s_done_cnt == base && n < 300) begin
      if (rand_ready) s_axis.i_tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    s_axis.i_tready = 1'b1;
    check_eq({tag, "_done_seen"}, 32'(s_done_cnt != base), 32'd1);
    repeat (4) step();
    check_eq({tag, "_done_once"}, 32'(s_done_cnt - base), 32'd1);
    check_eq({tag, "_busy_low"}, 32'(s_busy), 32'd0);
    check_eq({tag, "_tvalid_low"}, 32'(s_axis.o_tvalid), 32'd0);
  endtask

  // exp holds byte 0 in its most significant byte.
  task automatic check_frame(input string tag, input logic [63:0] exp);
    check_eq({tag, "_count"}, 32'(q_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < q_data.size()) begin
        check_eq($sformatf("%s_byte%0d", tag, i), 32'(q_data[i]), 32'(exp[63-8*i -: 8]));
        check_eq($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == 7));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  int base_done, base_err, n_wait, stall0;

  initial begin
    s_axis.i_tready = 1'b1;
    d_axis.i_tready = 1'b1;
    repeat (3) step();
    check_eq("rst_tvalid", 32'(s_axis.o_tvalid), 32'd0);
    check_eq("rst_tlast",  32'(s_axis.o_tlast),  32'd0);
    check_eq("rst_tdata",  32'(s_axis.o_tdata),  32'd0);
    check_eq("rst_busy",   32'(s_busy),          32'd0);
    check_eq("rst_done",   32'(s_done),          32'd0);
    check_eq("rst_err",    32'(s_err),           32'd0);
    check_eq("rst_d_busy", 32'(d_busy),          32'd0);
    rst = 1'b0;
    step();

    // 1: checkerboard, no backpressure
    $display("TEST 1 checkerboard");
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt; base_err = s_err_cnt;
    s_start_pulse();
    check_eq("t1_busy_armed", 32'(s_busy), 32'd1);
    s_vs_pulse();
    s_pixels(0, 64);
    wait_done("t1", base_done, 1'b0);
    check_frame("t1", 64'hAAAA_AAAA_AAAA_AAAA);
    check_eq("t1_no_err", 32'(s_err_cnt - base_err), 32'd0);

    // 2: single edge with random backpressure
    $display("TEST 2 single edge, backpressure");
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt; stall0 = stall_bad;
    s_start_pulse();
    s_vs_pulse();
    s_pixels(1, 64);
    wait_done("t2", base_done, 1'b1);
    check_frame("t2", 64'h0040_0000_0000_0000);
    check_eq("t2_stall_hold", 32'(stall_bad - stall0), 32'd0);

    // 3: short frame then a full all-edge frame
    $display("TEST 3 short frame");
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt; base_err = s_err_cnt;
    s_start_pulse();
    s_vs_pulse();
    s_pixels(2, 40);
    s_vs_pulse();
    s_pixels(2, 64);
    wait_done("t3", base_done, 1'b0);
    check_eq("t3_err_once", 32'(s_err_cnt - base_err), 32'd1);
    check_frame("t3", 64'hFFFF_FFFF_FFFF_FFFF);

    // 4: start arrives mid-frame; capture waits for the next vsync edge
    $display("TEST 4 start mid-frame");
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt;
    s_vs_pulse();
    s_pixels(2, 20);
    check_eq("t4_idle_ignores", 32'(s_busy), 32'd0);
    s_start_pulse();
    s_pixels(2, 20);
    check_eq("t4_armed_no_data", 32'(q_data.size()), 32'd0);
    s_vs_pulse();
    s_pixels(3, 64);
    wait_done("t4", base_done, 1'b0);
    check_frame("t4", 64'h8080_8080_8080_8080);

    // 5: abort after three bytes, then a fresh capture
    $display("TEST 5 abort during readout");
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt; base_err = s_err_cnt;
    s_start_pulse();
    s_vs_pulse();
    s_pixels(0, 64);
    n_wait = 0;
    while (q_data.size() < 3 && n_wait < 100) begin
      step();
      n_wait++;
    end
    check_eq("t5_three_bytes", 32'(q_data.size()), 32'd3);
    s_abort = 1'b1; s_axis.i_tready = 1'b0; step();
    s_abort = 1'b0; s_axis.i_tready = 1'b1;
    check_eq("t5_tvalid_low", 32'(s_axis.o_tvalid), 32'd0);
    check_eq("t5_tlast_low",  32'(s_axis.o_tlast),  32'd0);
    check_eq("t5_busy_low",   32'(s_busy),          32'd0);
    repeat (10) step();
    check_eq("t5_no_done",    32'(s_done_cnt - base_done), 32'd0);
    check_eq("t5_no_err",     32'(s_err_cnt - base_err),   32'd0);
    check_eq("t5_no_more",    32'(q_data.size()),          32'd3);
    q_data.delete(); q_last.delete();
    base_done = s_done_cnt;
    s_start_pulse();
    s_vs_pulse();
    s_pixels(4, 64);
    wait_done("t5b", base_done, 1'b0);
    check_frame("t5b", 64'h0000_0000_FFFF_FFFF);

    // 6: default 80x120 all-zero frame
    $display("TEST 6 default size, all zero");
    d_start = 1'b1; step(); d_start = 1'b0;
    d_vsync = 1'b1; step(); d_vsync = 1'b0; step();
    for (int i = 0; i < 9600; i++) begin
      d_de = 1'b1; d_data = 8'h00; step();
    end
    d_de = 1'b0;
    n_wait = 0;
    while (d_done_cnt == 0 && n_wait < 3000) begin
      step();
      n_wait++;
    end
    repeat (3) step();
    check_eq("t6_done",      32'(d_done_cnt), 32'd1);
    check_eq("t6_count",     32'(d_cnt),      32'd1200);
    check_eq("t6_nonzero",   32'(d_bad),      32'd0);
    check_eq("t6_last_cnt",  32'(d_last_cnt), 32'd1);
    check_eq("t6_last_pos",  32'(d_last_pos), 32'd1200);
    check_eq("t6_busy_low",  32'(d_busy),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
